// File: rtl/pc_fetch_predict_if.sv
// Fetch-PC bundle: EX resolution inputs and fetch-side prediction outputs.
// The fetch block takes the slave modport; the pipeline (or bench) takes master.
interface pc_fetch_predict_if #(
  parameter int XLEN = 32
);
  logic            StallF;
  logic            BranchE;
  logic            TakenE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] ImmExtE;
  logic            PredTakenE;
  logic [XLEN-1:0] PredTargetE;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;
  logic            PredTakenF;
  logic [XLEN-1:0] PredTargetF;
  logic            MispredictE;

  modport slave (
    input  StallF, BranchE, TakenE, PCE, ImmExtE, PredTakenE, PredTargetE,
    output PCF, PCPlus4F, PredTakenF, PredTargetF, MispredictE
  );

  modport master (
    output StallF, BranchE, TakenE, PCE, ImmExtE, PredTakenE, PredTargetE,
    input  PCF, PCPlus4F, PredTakenF, PredTargetF, MispredictE
  );
endinterface

// File: rtl/pc_fetch_predict.sv
// Fetch PC register with a direct-mapped BTB (2-bit counters) and EX redirect.
// One pc_fetch_btb_entry instance per BTB slot; lookup and update muxes in the top.
module pc_fetch_btb_entry #(
  parameter int XLEN = 32,
  parameter int TAGW = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic            taken,
  input  logic [TAGW-1:0] tag_in,
  input  logic [XLEN-1:0] tgt_in,
  output logic            valid,
  output logic [TAGW-1:0] tag,
  output logic [XLEN-1:0] tgt,
  output logic [1:0]      ctr
);
  logic match;
  assign match = valid && (tag == tag_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      tgt   <= '0;
      ctr   <= 2'b01;
    end else if (we) begin
      tgt <= tgt_in;
      if (match) begin
        // saturating 2-bit counter, 00..11
        if (taken) ctr <= (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        else       ctr <= (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
      end else begin
        valid <= 1'b1;
        tag   <= tag_in;
        ctr   <= taken ? 2'b10 : 2'b01;
      end
    end
  end
endmodule

module pc_fetch_predict #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              IMM_SHIFT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  pc_fetch_predict_if.slave        bus
);
  localparam int IDXW = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDXW - 2;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [IDXW-1:0] idx_f, idx_e;
  logic [TAGW-1:0] tag_f, tag_e;
  logic            hit_f, ptk_f;
  logic [XLEN-1:0] ptgt_f;
  logic [XLEN-1:0] tgt_e, redirect;
  logic            mis_e;

  logic [BTB_DEPTH-1:0]           e_valid;
  logic [BTB_DEPTH-1:0]           e_we;
  logic [BTB_DEPTH-1:0][TAGW-1:0] e_tag;
  logic [BTB_DEPTH-1:0][XLEN-1:0] e_tgt;
  logic [BTB_DEPTH-1:0][1:0]      e_ctr;

  assign idx_f = pc_q[IDXW+1:2];
  assign tag_f = pc_q[XLEN-1:IDXW+2];
  assign idx_e = bus.PCE[IDXW+1:2];
  assign tag_e = bus.PCE[XLEN-1:IDXW+2];

  genvar g;
  generate
    for (g = 0; g < BTB_DEPTH; g++) begin : g_btb
      pc_fetch_btb_entry #(.XLEN(XLEN), .TAGW(TAGW)) u_ent (
        .clk    (clk),
        .rst    (rst),
        .we     (e_we[g]),
        .taken  (bus.TakenE),
        .tag_in (tag_e),
        .tgt_in (tgt_e),
        .valid  (e_valid[g]),
        .tag    (e_tag[g]),
        .tgt    (e_tgt[g]),
        .ctr    (e_ctr[g])
      );
    end
  endgenerate

  // one-hot write enable; updates are independent of StallF
  always_comb begin
    e_we = '0;
    if (bus.BranchE) e_we[idx_e] = 1'b1;
  end

  // lookup reads pre-update entry contents, so a same-index write shows next cycle
  assign pc_plus4 = pc_q + XLEN'(4);
  assign hit_f    = e_valid[idx_f] && (e_tag[idx_f] == tag_f);
  assign ptk_f    = hit_f && e_ctr[idx_f][1];
  assign ptgt_f   = ptk_f ? e_tgt[idx_f] : pc_plus4;

  assign tgt_e    = bus.PCE + (bus.ImmExtE << IMM_SHIFT);
  assign redirect = bus.TakenE ? tgt_e : bus.PCE + XLEN'(4);
  assign mis_e    = bus.BranchE &&
                    ((bus.TakenE != bus.PredTakenE) ||
                     (bus.TakenE && (tgt_e != bus.PredTargetE)));

  always_ff @(posedge clk) begin
    if (rst)              pc_q <= RESET_PC;
    else if (mis_e)       pc_q <= redirect;
    else if (!bus.StallF) pc_q <= ptgt_f;
  end

  assign bus.PCF         = pc_q;
  assign bus.PCPlus4F    = pc_plus4;
  assign bus.PredTakenF  = ptk_f;
  assign bus.PredTargetF = ptgt_f;
  assign bus.MispredictE = mis_e;
endmodule

// File: tb/tb_pc_fetch_predict.sv
// Directed bench: driver pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the fetch outputs.
module tb_pc_fetch_predict;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_predict_if #(.XLEN(32)) bus ();

  pc_fetch_predict #(
    .XLEN(32), .BTB_DEPTH(16), .RESET_PC(32'h0), .IMM_SHIFT(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] pcf;
    bit          ptk;
    logic [31:0] ptgt;
    bit          mis;
    bit          cmis;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // monitor: one expectation per checked cycle, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        cmp(e.nm, "PCF",         bus.PCF,                 e.pcf);
        cmp(e.nm, "PCPlus4F",    bus.PCPlus4F,            e.pcf + 32'd4);
        cmp(e.nm, "PredTakenF",  {31'd0, bus.PredTakenF}, {31'd0, e.ptk});
        cmp(e.nm, "PredTargetF", bus.PredTargetF,         e.ptgt);
        if (e.cmis) cmp(e.nm, "MispredictE", {31'd0, bus.MispredictE}, {31'd0, e.mis});
      end
    end
  end

  task automatic step(input string nm, input bit r, s, b, t,
                      input logic [31:0] pce, imm, input bit pk, input logic [31:0] pt,
                      input bit chk, input logic [31:0] epcf, input bit eptk,
                      input logic [31:0] eptgt, input bit emis, input bit cmis);
    exp_t e;
    @(posedge clk); #1;
    rst = r; bus.StallF = s; bus.BranchE = b; bus.TakenE = t;
    bus.PCE = pce; bus.ImmExtE = imm; bus.PredTakenE = pk; bus.PredTargetE = pt;
    if (chk) begin
      e.nm = nm; e.pcf = epcf; e.ptk = eptk; e.ptgt = eptgt; e.mis = emis; e.cmis = cmis;
      q.push_back(e);
    end
  endtask

  task automatic idle(input string nm, input bit s, input logic [31:0] epcf,
                      input bit eptk, input logic [31:0] eptgt);
    step(nm, 0, s, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, epcf, eptk, eptgt, 0, 1);
  endtask

  task automatic br(input string nm, input bit s, t, input logic [31:0] pce, imm,
                    input bit pk, input logic [31:0] pt, input logic [31:0] epcf,
                    input bit eptk, input logic [31:0] eptgt, input bit emis);
    step(nm, 0, s, 1, t, pce, imm, pk, pt, 1, epcf, eptk, eptgt, emis, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.StallF = 0; bus.BranchE = 0; bus.TakenE = 0; bus.PCE = '0;
    bus.ImmExtE = '0; bus.PredTakenE = 0; bus.PredTargetE = '0;

    step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h4, 0, 1);
    idle("seq0", 0, 32'h00, 0, 32'h04);
    idle("seq1", 0, 32'h04, 0, 32'h08);
    idle("seq2", 0, 32'h08, 0, 32'h0C);
    idle("seq3", 0, 32'h0C, 0, 32'h10);
    idle("stall0", 1, 32'h10, 0, 32'h14);
    idle("stall1", 1, 32'h10, 0, 32'h14);
    idle("stall2", 1, 32'h10, 0, 32'h14);
    idle("release", 0, 32'h10, 0, 32'h14);
    // cold taken branch at 0x20 -> target 0x30, allocates idx 8 with ctr 10
    br("cold_tk", 0, 1, 32'h20, 32'h8, 0, 32'h24, 32'h14, 0, 32'h18, 1);
    br("redir20", 0, 1, 32'h10, 32'h8, 0, 32'h14, 32'h30, 0, 32'h34, 1);
    idle("hit20", 1, 32'h20, 1, 32'h30);
    // not-taken training; lookup in the update cycle still sees ctr 10
    br("nt1", 1, 0, 32'h20, 32'h8, 1, 32'h30, 32'h20, 1, 32'h30, 1);
    br("nt2", 0, 0, 32'h20, 32'h8, 0, 32'h24, 32'h24, 0, 32'h28, 0);
    br("back20", 0, 0, 32'h1C, 32'h8, 1, 32'h2C, 32'h28, 0, 32'h2C, 1);
    idle("ctr00", 1, 32'h20, 0, 32'h24);
    br("tk_ok", 1, 1, 32'h20, 32'h8, 1, 32'h30, 32'h20, 0, 32'h24, 0);
    idle("ctr01", 1, 32'h20, 0, 32'h24);
    br("tgt_mis", 0, 1, 32'h20, 32'h8, 1, 32'h34, 32'h20, 0, 32'h24, 1);
    // mispredict overrides stall
    br("mis_stall", 1, 1, 32'hF0, 32'h8, 0, 32'hF4, 32'h30, 0, 32'h34, 1);
    idle("at100", 0, 32'h100, 0, 32'h104);
    // reset wins over a mispredict + update in the same cycle
    step("rst_mis", 1, 0, 1, 1, 32'h40, 32'h8, 0, 32'h44, 1, 32'h104, 0, 32'h108, 0, 0);
    br("post_rst", 0, 0, 32'h1C, 32'h8, 1, 32'h2C, 32'h0, 0, 32'h4, 1);
    br("clr20", 0, 0, 32'h3C, 32'h8, 1, 32'h4C, 32'h20, 0, 32'h24, 1);
    br("clr40", 0, 1, 32'hFFFF_FFF0, 32'h6, 0, 32'hFFFF_FFF4, 32'h40, 0, 32'h44, 1);
    idle("wrap_st", 1, 32'hFFFF_FFFC, 0, 32'h0);
    idle("wrap_go", 0, 32'hFFFF_FFFC, 0, 32'h0);
    // alias: 0x40 and 0x80 share idx 0
    br("al40", 0, 1, 32'h40, 32'h8, 1, 32'h50, 32'h0, 0, 32'h4, 0);
    br("to40", 0, 0, 32'h3C, 32'h8, 1, 32'h4C, 32'h4, 0, 32'h8, 1);
    br("al80", 0, 1, 32'h80, 32'h8, 0, 32'h84, 32'h40, 1, 32'h50, 1);
    br("to40b", 0, 0, 32'h3C, 32'h8, 1, 32'h4C, 32'h90, 0, 32'h94, 1);
    br("evict40", 0, 0, 32'h7C, 32'h8, 1, 32'h8C, 32'h40, 0, 32'h44, 1);
    br("neg_imm", 0, 1, 32'h80, 32'hFFFF_FFF8, 1, 32'h90, 32'h80, 1, 32'h90, 1);
    idle("at70", 0, 32'h70, 0, 32'h74);

    @(posedge clk); #1;
    bus.BranchE = 0;
    @(negedge clk); #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch_predict.md
Name: pc_fetch_predict

Overview:
- Next-generation fetch-PC block: owns the PC register and chooses the next fetch address.
- Sequential PC+4, a predicted target from a direct-mapped branch target buffer (BTB) with 2-bit counters, or an execute-stage redirect.
- EX branch target is PCE + (ImmExtE << IMM_SHIFT). Sits between instruction memory and the IF/ID register; EX resolution feeds back into it.

Parameters:
- XLEN, 32, address/data width.
- BTB_DEPTH, 16, BTB entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, PCF value after reset.
- IMM_SHIFT, 1, left shift applied to ImmExtE when forming the branch target.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- StallF  in  1  hold PCF; no prediction advance
- BranchE  in  1  EX holds a resolved conditional branch
- TakenE  in  1  EX branch outcome
- PCE  in  XLEN  PC of the EX instruction
- ImmExtE  in  XLEN  sign-extended EX immediate
- PredTakenE  in  1  prediction carried down the pipe with the EX instruction
- PredTargetE  in  XLEN  predicted next PC carried with the EX instruction
- PCF  out  XLEN  current fetch PC (registered)
- PCPlus4F  out  XLEN  PCF + 4
- PredTakenF  out  1  BTB predicts taken for PCF
- PredTargetF  out  XLEN  predicted next PC for PCF
- MispredictE  out  1  redirect/flush request for IF and ID

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, and takes precedence over everything.
- On reset: PCF=RESET_PC; all BTB valid bits=0; all counters=2'b01. Outputs are derived combinationally from that state.
- Indexing: idx=PCF[log2(BTB_DEPTH)+1:2]; tag=PCF[XLEN-1:log2(BTB_DEPTH)+2]. Bits [1:0] are ignored.
- Lookup (combinational, same cycle as PCF): hit = valid[idx] & tag match.
  - PredTakenF = hit & ctr[idx][1].
  - PredTargetF = target[idx] when PredTakenF, else PCPlus4F.
- Arithmetic: TargetE = PCE + (ImmExtE << IMM_SHIFT), truncated to XLEN. PCPlus4F = PCF + 4, wrapping mod 2^XLEN. There is no overflow detection.
- MispredictE = BranchE & ((TakenE != PredTakenE) | (TakenE & (TargetE != PredTargetE))).
  - Redirect address = TargetE if TakenE, else PCE + 4.
- Next-PC priority, evaluated at each edge:
  - rst
  - MispredictE (overrides StallF)
  - StallF (hold)
  - PredTargetF
- BTB update on any edge with BranchE=1 and rst=0, at entry idxE/tagE derived from PCE:
  - Entry already matches (valid & tag): counter saturating +1 if TakenE, -1 otherwise (00..11). Target overwritten with TargetE.
  - Entry does not match: allocate, i.e. valid=1, tag=tagE, target=TargetE, counter=2'b10 if TakenE, else 2'b01.
  - Updates occur regardless of StallF.
- Same cycle, same index for fetch lookup and EX update: lookup uses pre-update contents; the write becomes visible the next cycle.
- Reset mid-operation: a pending mispredict or update in the rst cycle is discarded.
- Aliasing: a tag mismatch is a miss. A later allocation evicts the prior entry.

Test Plan:
- Reset and sequential fetch: assert rst for 2 cycles, then run 4 cycles free -> PCF 0,4,8,12; PredTakenF=0 throughout; MispredictE=0.
- Stall: StallF=1 for 3 cycles at PCF=0x10 -> PCF holds 0x10; release -> 0x14.
- Cold taken branch: BranchE=1, TakenE=1, PCE=0x20, ImmExtE=0x8, PredTakenE=0 -> MispredictE=1; next PCF=0x30; entry idx 8 valid, ctr=10. PCF=0x20 later -> PredTakenF=1, PredTargetF=0x30.
- Not-taken training: same branch resolved not-taken twice -> first resolution causes a mispredict with redirect to 0x24 and ctr 01; second gives ctr 00 and no mispredict; PredTakenF=0 at PCF=0x20.
- Priority: StallF=1 together with MispredictE (taken, target 0x100) -> PCF=0x100 next cycle. With rst=1 in the same cycle -> PCF=RESET_PC and the BTB stays invalid.
- Wrap/alias: PCF=0xFFFF_FFFC with stall released -> PCF=0x0. Branches at 0x40 and 0x80 (BTB_DEPTH=16, same idx 0) -> second allocation evicts the first; lookup at 0x40 misses.
